// File: rtl/pru_pkg.sv
// pru_pkg: shared types and default field layout for the PRU command decoder.
package pru_pkg;
   typedef enum logic [1:0] {RECT = 2'b00, CIRCLE = 2'b01, BITMAP = 2'b10} shape_t;
   typedef enum logic {HDR = 1'b0, ARG = 1'b1} state_t;
   localparam int ROW_W_DEF = 9;
   localparam int COL_W_DEF = 10;
   localparam int COLOR_W_DEF = 2;
   localparam int HDR_COL_LO = ROW_W_DEF;
   localparam int HDR_COLOR_LO = HDR_COL_LO + COL_W_DEF;
   localparam int HDR_SHAPE_LO = HDR_COLOR_LO + COLOR_W_DEF;
   localparam int HDR_W_DEF = HDR_SHAPE_LO + 2;
   localparam int ARG_W_LO = ROW_W_DEF;
   localparam int ARG_SUB_BIT = ARG_W_LO + COL_W_DEF;
   localparam int ARG_CL_BIT = ARG_SUB_BIT + 1;
endpackage

// File: rtl/pru_cmd_fifo.sv
// pru_cmd_fifo: synchronous FIFO of complete commands with occupancy level.
module pru_cmd_fifo #(
   parameter int WIDTH = 55,
   parameter int DEPTH = 4,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty,
   output logic [AW:0]      level
);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0] wptr, rptr;
   logic push_ok, pop_ok;
   assign full = level == (AW+1)'(DEPTH);
   assign empty = level == '0;
   assign push_ok = push && !full;
   assign pop_ok = pop && !empty;
   assign rdata = mem[rptr];
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         wptr <= '0;
         rptr <= '0;
         level <= '0;
      end else begin
         wptr <= wptr + AW'(push_ok);
         rptr <= rptr + AW'(pop_ok);
         level <= level + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
      end
   always_ff @(posedge clk)
      if (push_ok) mem[wptr] <= wdata;
endmodule

// File: rtl/pru_cmd_decoder.sv
// pru_cmd_decoder: assembles header+argument host words into queued draw commands.
// Optional header timeout with sticky err under PRU_DEC_TIMEOUT_EN.
module pru_cmd_decoder
   import pru_pkg::*;
#(
   parameter int ROW_W = ROW_W_DEF,
   parameter int COL_W = COL_W_DEF,
   parameter int COLOR_W = COLOR_W_DEF,
   parameter int FIFO_DEPTH = 4,
   parameter int TIMEOUT = 1024,
   localparam int LW = $clog2(FIFO_DEPTH) + 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               wr,
   input  logic [31:0]        wr_data,
   output logic               wr_ack,
   input  logic               engine_ready,
   output logic               start,
   output logic [ROW_W-1:0]   row,
   output logic [COL_W-1:0]   col,
   output logic [COLOR_W-1:0] color,
   output logic [1:0]         shape_select,
   output logic [ROW_W-1:0]   height_radius,
   output logic [COL_W-1:0]   width,
   output logic               subtract,
   output logic               color_load,
   output logic [31:0]        bitmap_address,
   output logic [LW-1:0]      fifo_level,
   output logic               busy,
   output logic               err
);
   localparam int COL_LO = ROW_W;
   localparam int COLOR_LO = COL_LO + COL_W;
   localparam int SHAPE_LO = COLOR_LO + COLOR_W;
   localparam int HDR_W = SHAPE_LO + 2;
   if (HDR_W > 32 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TIMEOUT < 1) begin : g_bad_params
      $error("pru_cmd_decoder: illegal parameter set");
   end
   state_t state, state_d;
   logic [HDR_W-1:0] hdr_q, e_hdr;
   logic [31:0] e_arg;
   logic accept, push, issue, full, empty, tmo;
   shape_t e_shape;
   pru_cmd_fifo #(.WIDTH(HDR_W + 32), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk(clk), .rst_n(rst_n), .push(push), .wdata({hdr_q, wr_data}), .pop(issue),
      .rdata({e_hdr, e_arg}), .full(full), .empty(empty), .level(fifo_level)
   );
   always_comb begin
      accept = wr && (state == HDR || !full);
      push = accept && state == ARG;
      state_d = state == HDR ? (wr ? ARG : HDR) : (push || tmo ? HDR : ARG);
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state <= HDR;
         hdr_q <= '0;
         wr_ack <= 1'b0;
      end else begin
         state <= state_d;
         wr_ack <= accept;
         if (state == HDR && wr) hdr_q <= wr_data[HDR_W-1:0];
      end
`ifdef PRU_DEC_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT + 1);
   logic [TW-1:0] tcnt;
   // A full FIFO stalls the host, so that wait is not charged to the timeout.
   assign tmo = state == ARG && !full && !wr && tcnt == TW'(TIMEOUT - 1);
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         tcnt <= '0;
         err <= 1'b0;
      end else begin
         tcnt <= (state == HDR || accept) ? '0 : tcnt + TW'(!full);
         err <= err | tmo;
      end
`else
   assign tmo = 1'b0;
   assign err = 1'b0;
`endif
   assign issue = !empty && engine_ready && !start;
   assign busy = state == ARG || fifo_level != '0;
   assign e_shape = shape_t'(e_hdr[SHAPE_LO +: 2]);
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         start <= 1'b0;
         row <= '0;
         col <= '0;
         color <= '0;
         shape_select <= '0;
         height_radius <= '0;
         width <= '0;
         subtract <= 1'b0;
         color_load <= 1'b0;
         bitmap_address <= '0;
      end else begin
         start <= issue;
         if (issue) begin
            row <= e_hdr[ROW_W-1:0];
            col <= e_hdr[COL_LO +: COL_W];
            color <= e_hdr[COLOR_LO +: COLOR_W];
            shape_select <= e_shape;
            if (e_shape[1]) bitmap_address <= e_arg;
            else begin
               height_radius <= e_arg[ROW_W-1:0];
               width <= e_arg[ROW_W +: COL_W];
               subtract <= e_arg[ROW_W+COL_W];
               color_load <= e_arg[ROW_W+COL_W+1];
            end
         end
      end
endmodule
